// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment encoder/decoder pair: segment bit positions,
// the reference encoding function and the decoder FSM state type.
package display_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic [0:0] {SETTLE = 1'b0, HOLD = 1'b1} state_t;

    // Active-low segment levels. Digits 0..7 light their segments and drive DP with
    // the sign bit; magnitudes 8..15 blank the whole display, sign included.
    function automatic logic [7:0] seg_encode(input logic sinal, input logic [3:0] diff);
        logic [6:0] on;
        logic [7:0] seg;
        case (diff)
            4'd0:    on = 7'b1111110;
            4'd1:    on = 7'b0110000;
            4'd2:    on = 7'b1101101;
            4'd3:    on = 7'b1111001;
            4'd4:    on = 7'b0110011;
            4'd5:    on = 7'b1011011;
            4'd6:    on = 7'b1011111;
            4'd7:    on = 7'b1110000;
            default: on = 7'b0000000;
        endcase
        seg = 8'hFF;
        if (diff < 4'd8) begin
            seg[SEG_A]  = ~on[6];
            seg[SEG_B]  = ~on[5];
            seg[SEG_C]  = ~on[4];
            seg[SEG_D]  = ~on[3];
            seg[SEG_E]  = ~on[2];
            seg[SEG_F]  = ~on[1];
            seg[SEG_G]  = ~on[0];
            seg[SEG_DP] = sinal;
        end
        return seg;
    endfunction

endpackage

// File: rtl/display_seg_decoder_filter.sv
// Stability filter: optional 2-flop input synchronizer (SEG_INPUT_SYNC_EN),
// sample register, saturating match counter and the level "stable" indication.
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_seg,
    output logic [7:0] o_samp,
    output logic       o_stable
);
    import display_pkg::*;

    logic [7:0] w_in;
    logic [7:0] r_samp;
    logic [7:0] r_cnt;

`ifdef SEG_INPUT_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
        end else begin
            r_sync1 <= i_seg;
            r_sync2 <= r_sync1;
        end
    end
    assign w_in = r_sync2;
`else
    assign w_in = i_seg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp <= 8'hFF;
            r_cnt  <= 8'd0;
        end else begin
            r_samp <= w_in;
            if (w_in != r_samp)
                r_cnt <= 8'd0;
            else if (r_cnt != 8'(STABLE_CYCLES))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // Held as a level so a pattern that settled while the consumer stalled is still seen later.
    assign o_samp   = r_samp;
    assign o_stable = (r_cnt >= 8'(STABLE_CYCLES - 1));

endmodule

// File: rtl/display_seg_decoder.sv
// 7-segment pattern decoder: waits for a stable segment pattern, reverse-maps it to
// {sinal, diff} and hands each new value out over valid/ready. See SEG_INPUT_SYNC_EN.
module display_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] diff,
    output logic       sinal,
    output logic       err,
    output logic       ambiguous,
    output logic       overrun
);
    import display_pkg::*;

    logic [7:0]  w_samp;
    logic        w_stable;
    logic [31:0] w_match;
    logic [4:0]  w_idx;
    logic        w_err;
    logic        w_amb;
    logic        w_new;

    state_t      r_state;
    logic [7:0]  r_last;
    logic        r_last_vld;

    seg_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .i_seg    (seg_in),
        .o_samp   (w_samp),
        .o_stable (w_stable)
    );

    for (genvar gi = 0; gi < 32; gi++) begin : g_match
        localparam logic [4:0] IDX = 5'(gi);
        assign w_match[gi] = (seg_encode(IDX[4], IDX[3:0]) == w_samp);
    end

    always_comb begin
        w_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (w_match[i])
                w_idx = 5'(i);
        end
    end

    assign w_err = ~|w_match;
    assign w_amb = |(w_match & (w_match - 32'd1));
    assign w_new = w_stable && (!r_last_vld || (w_samp != r_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SETTLE;
            out_valid  <= 1'b0;
            diff       <= 4'd0;
            sinal      <= 1'b0;
            err        <= 1'b0;
            ambiguous  <= 1'b0;
            overrun    <= 1'b0;
            r_last     <= 8'd0;
            r_last_vld <= 1'b0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (w_new) begin
                        sinal      <= w_idx[4];
                        diff       <= w_idx[3:0];
                        err        <= w_err;
                        ambiguous  <= w_amb;
                        out_valid  <= 1'b1;
                        r_last     <= w_samp;
                        r_last_vld <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    // A pattern settling on the handshake edge is not lost; SETTLE picks it up next.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= SETTLE;
                    end else if (w_new) begin
                        overrun <= 1'b1;
                    end
                end
                default: r_state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_seg_decoder.sv
// Directed-vector bench for display_seg_decoder (honours SEG_INPUT_SYNC_EN for latency).
module tb_display_seg_decoder;

    localparam int SC = 4;
`ifdef SEG_INPUT_SYNC_EN
    localparam int LAT = SC + 2;
`else
    localparam int LAT = SC;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] diff;
    logic       sinal;
    logic       err;
    logic       ambiguous;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] seg;
        logic       s;
        logic [3:0] d;
        logic       e;
        logic       a;
    } vec_t;

    vec_t vecs[11];

    display_seg_decoder #(.STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .diff      (diff),
        .sinal     (sinal),
        .err       (err),
        .ambiguous (ambiguous),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: applies v.seg, waits for the report, checks latency/fields/pulse end.
    task automatic run_vec(input vec_t v, input string tag);
        int k;
        bit found;
        seg_in = v.seg;
        found = 0;
        k = 0;
        while (!found && k < 40) begin
            cyc();
            if (out_valid) found = 1;
            else k++;
        end
        chk({tag, "_latency"}, found ? k : -1, LAT);
        chk({tag, "_sinal"}, int'(sinal), int'(v.s));
        chk({tag, "_diff"}, int'(diff), int'(v.d));
        chk({tag, "_err"}, int'(err), int'(v.e));
        chk({tag, "_amb"}, int'(ambiguous), int'(v.a));
        $display("vec %s seg=%08b -> valid=%0d sinal=%0d diff=%0d err=%0d amb=%0d",
                 tag, v.seg, found, sinal, diff, err, ambiguous);
        if (out_ready) begin
            cyc();
            chk({tag, "_pulse_end"}, int'(out_valid), 0);
        end
    endtask

    initial begin
        int hi;
        vec_t v;
        vecs[0]  = '{8'b0000_0010, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{8'b1001_1110, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[2]  = '{8'b0010_0100, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF,        1'b0, 4'd8, 1'b0, 1'b1};
        vecs[4]  = '{8'h00,        1'b0, 4'd0, 1'b1, 1'b0};
        vecs[5]  = '{8'b0000_0011, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{8'b0001_1111, 1'b1, 4'd7, 1'b0, 1'b0};
        vecs[7]  = '{8'b0100_1000, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[8]  = '{8'b0000_1101, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[9]  = '{8'b1001_1000, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[10] = '{8'b0100_0001, 1'b1, 4'd6, 1'b0, 1'b0};

        reset     = 1'b1;
        out_ready = 1'b1;
        seg_in    = 8'b0000_0010;
        repeat (3) cyc();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_sinal", int'(sinal), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_amb", int'(ambiguous), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Reported pattern, short excursion, return: nothing more may be reported.
        run_vec(vecs[0], "glitch_base");
        seg_in = 8'b0010_0100;
        repeat (2) cyc();
        seg_in = 8'b0000_0010;
        hi = 0;
        repeat (12) begin
            cyc();
            if (out_valid) hi++;
        end
        chk("glitch_quiet", hi, 0);
        $display("glitch excursion: valid pulses=%0d", hi);

        // Consumer stall: second stable pattern overruns, then is reported after the handshake.
        out_ready = 1'b0;
        run_vec(vecs[2], "stall");
        chk("stall_no_overrun", int'(overrun), 0);
        seg_in = 8'b1001_1110;
        repeat (LAT + 6) cyc();
        chk("stall_valid_held", int'(out_valid), 1);
        chk("stall_diff_frozen", int'(diff), 2);
        chk("stall_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        cyc();
        chk("hs_valid_drop", int'(out_valid), 0);
        cyc();
        chk("late_valid", int'(out_valid), 1);
        chk("late_diff", int'(diff), 1);
        cyc();
        chk("late_pulse_end", int'(out_valid), 0);
        chk("overrun_sticky", int'(overrun), 1);
        $display("stall sequence: overrun=%0d diff=%0d", overrun, diff);

        // Reset while a result is pending.
        out_ready = 1'b0;
        v = vecs[7];
        run_vec(v, "pend");
        reset = 1'b1;
        cyc();
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_err", int'(err), 0);
        $display("mid-handshake reset: valid=%0d overrun=%0d", out_valid, overrun);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
